bridge_responder: RTL and testbench

Device-side end of the CPU data bridge. It accepts single-beat load/store requests from the pipeline's MEM stage and decodes each address to either the external data-RAM port or an internal 32-bit timer device. It returns read data with a ready/stall handshake and drives the timer's hardware interrupt line toward CP0.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/bridge_timer.sv | 90 +++++++++
 rtl/bridge_responder.sv | 144 ++++++++++++++
 tb/tb_bridge_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU data-bridge responder and its timer.
// Optional feature macro: BRIDGE_TIMEOUT_EN (data-RAM wait timeout with bus error).
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte offsets inside the 16-byte timer window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;

    // CTRL = {IM, MODE[1:0], EN}
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/bridge_timer.sv
// 32-bit down-counting timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// level interrupt. Zero-wait register interface with a combinational read port.
module bridge_timer
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl_q,   ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q,  count_d;
    logic        irq_q,    irq_d;

    logic       en;
    logic       im;
    logic [1:0] mode;

    assign en   = ctrl_q[CTRL_EN];
    assign im   = ctrl_q[CTRL_IM];
    assign mode = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latch).
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        if (en) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                count_d = '0;
                if (im) irq_d = 1'b1;
                // Reserved modes 2/3 stop like one-shot
                if (mode != MODE_RELOAD) ctrl_d[CTRL_EN] = 1'b0;
            end else if (mode == MODE_RELOAD) begin
                count_d = preset_q;
            end
        end

        // Bus writes are applied last so they override counting on a collision
        if (we) begin
            case (off)
                OFF_CTRL: begin
                    ctrl_d = wdata[3:0];
                    irq_d  = 1'b0;
                end
                OFF_PRESET: begin
                    preset_d = wdata;
                    count_d  = wdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (off)
            OFF_CTRL:   rdata = {28'd0, ctrl_q};
            OFF_PRESET: rdata = preset_q;
            OFF_COUNT:  rdata = count_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: rtl/bridge_responder.sv
// Device side of the CPU data bridge: decodes requests to the data-RAM port or the
// internal timer. Optional feature macro: BRIDGE_TIMEOUT_EN (abort stalled RAM accesses).
module bridge_responder
    import bridge_pkg::*;
#(
    parameter logic [31:0] TIMER_BASE  = 32'h0000_7F00,
    parameter int          DM_ADDR_W   = 12
`ifdef BRIDGE_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [3:0]           req_be,
    input  logic [31:0]          req_wdata,
    output logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 dm_en,
    output logic [3:0]           dm_we,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata,
    output logic                 timer_irq,
    output logic                 bus_err
);

    state_e               state_q,      state_d;
    logic                 dm_en_q,      dm_en_d;
    logic [3:0]           dm_we_q,      dm_we_d;
    logic [DM_ADDR_W-1:0] dm_addr_q,    dm_addr_d;
    logic [31:0]          dm_wdata_q,   dm_wdata_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            bus_err_q,  bus_err_d;
`endif

    logic        is_timer;
    logic        timer_sel;
    logic [31:0] timer_rdata;

    assign is_timer  = (req_addr[31:4] == TIMER_BASE[31:4]);
    // Timer accesses complete combinationally, only while no RAM access is in flight
    assign timer_sel = (state_q == IDLE) && req_valid && is_timer;

    bridge_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .we    (timer_sel && req_we),
        .off   (req_addr[3:0]),
        .wdata (req_wdata),
        .rdata (timer_rdata),
        .irq   (timer_irq)
    );

    always_comb begin
        state_d      = state_q;
        dm_en_d      = 1'b0;
        dm_we_d      = 4'b0000;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        resp_rdata_d = resp_rdata_q;
`ifdef BRIDGE_TIMEOUT_EN
        wait_cnt_d   = '0;
        bus_err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid && !is_timer) begin
                    dm_en_d    = 1'b1;
                    dm_we_d    = req_we ? req_be : 4'b0000;
                    dm_addr_d  = req_addr[DM_ADDR_W+1:2];
                    dm_wdata_d = req_wdata;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    resp_rdata_d = dm_rdata;
                    state_d      = RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    resp_rdata_d = ERR_PATTERN;
                    bus_err_d    = 1'b1;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            dm_en_q      <= 1'b0;
            dm_we_q      <= 4'b0000;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            resp_rdata_q <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt_q   <= '0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dm_en_q      <= dm_en_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign resp_ready = (state_q == RESP) || timer_sel;
    assign resp_rdata = timer_sel ? timer_rdata : resp_rdata_q;
    assign dm_en      = dm_en_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;

`ifdef BRIDGE_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_responder.sv
// Directed self-checking bench for bridge_responder: RAM load/store latency, timer
// one-shot and auto-reload, async reset mid-access, and the optional RAM timeout.
module tb_bridge_responder;

    localparam logic [31:0] TIMER_BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        dm_en;
    logic [3:0]  dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        timer_irq;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    bridge_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .dm_en      (dm_en),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .timer_irq  (timer_irq),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with the FSM idle; leaves at a negedge with the FSM idle again.
    task automatic ram_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input int ack_dly,
                              input logic [31:0] ack_data, input int exp_lat,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input string tag);
        logic seen;
        seen      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clk);
            dm_ack = 1'b0;
            if (resp_ready) begin
                seen = 1'b1;
                check({tag, "_latency"}, c, exp_lat);
                if (!we) check({tag, "_rdata"}, resp_rdata, exp_rdata);
                check({tag, "_bus_err"}, bus_err, exp_err);
            end else begin
                if (c == 1) begin
                    check({tag, "_dm_en"}, dm_en, 1'b1);
                    check({tag, "_dm_we"}, dm_we, we ? be : 4'b0000);
                    check({tag, "_dm_addr"}, dm_addr, (addr >> 2) & 32'hFFF);
                    if (we) check({tag, "_dm_wdata"}, dm_wdata, wdata);
                end
                if (c == 2) check({tag, "_dm_en_pulse"}, dm_en, 1'b0);
                if (ack_dly >= 0 && c == 1 + ack_dly) begin
                    dm_ack   = 1'b1;
                    dm_rdata = ack_data;
                end
            end
        end
        check({tag, "_resp_seen"}, seen, 1'b1);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, resp_ready, 1'b0);
        check({tag, "_idle_bus_err"}, bus_err, 1'b0);
    endtask

    task automatic timer_wr(input logic [3:0] off, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = TIMER_BASE | {28'd0, off};
        req_be    = 4'b0001;
        req_wdata = data;
        #1 check("tmr_wr_ready", resp_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic timer_rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = TIMER_BASE | {28'd0, off};
        #1;
        check({tag, "_ready"}, resp_ready, 1'b1);
        check(tag, resp_rdata, exp);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        dm_ack    = 1'b0;
        dm_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_ready", resp_ready, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_dm_en", dm_en, 1'b0);
        check("rst_dm_we", dm_we, 4'b0000);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_irq", timer_irq, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        ram_access(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1, 32'h1234_5678, 3,
                   32'h1234_5678, 1'b0, "load");
        ram_access(1'b1, 32'h0000_0008, 4'b0011, 32'hAABB_CCDD, 5, 32'h0, 7,
                   32'h0, 1'b0, "store");

        // One-shot, IM=1
        timer_wr(OFF_PRESET_TB(), 32'd5);
        timer_wr(4'h0, 32'h9);
        for (int i = 0; i < 6; i++) begin
            check("oneshot_irq", timer_irq, (i == 5));
            timer_rd(4'h8, 32'(5 - i), "oneshot_count");
        end
        timer_rd(4'h8, 32'd0, "oneshot_count_hold");
        timer_rd(4'h0, 32'h8, "oneshot_ctrl_en_clr");
        timer_rd(4'h4, 32'd5, "oneshot_preset");
        timer_rd(4'hC, 32'd0, "reg_c_zero");
        check("oneshot_irq_level", timer_irq, 1'b1);
        timer_wr(4'h0, 32'h0);
        check("ctrl_wr_clears_irq", timer_irq, 1'b0);

        // Auto-reload, IM=1; steps 4 and 6 are CTRL writes, step 6 lands on the irq edge
        timer_wr(4'h4, 32'd3);
        timer_wr(4'h0, 32'hB);
        for (int i = 0; i < 12; i++) begin
            check("reload_irq", timer_irq, (i == 3 || i == 4 || i == 11));
            if (i == 4 || i == 6) timer_wr(4'h0, 32'hB);
            else timer_rd(4'h8, 32'(3 - (i % 4)), "reload_count");
        end
        check("reload_irq_before_rst", timer_irq, 1'b1);

        // Asynchronous reset during a RAM access
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0080;
        @(negedge clk);
        check("rstmid_dm_en_before", dm_en, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("rstmid_dm_en", dm_en, 1'b0);
        check("rstmid_dm_addr", dm_addr, 32'h0);
        check("rstmid_resp_ready", resp_ready, 1'b0);
        check("rstmid_resp_rdata", resp_rdata, 32'h0);
        check("rstmid_irq", timer_irq, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dm_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rstmid_late_ack_ready", resp_ready, 1'b0);
            check("rstmid_late_ack_dm_en", dm_en, 1'b0);
            @(negedge clk);
        end
        timer_rd(4'h0, 32'h0, "rstmid_ctrl");
        timer_rd(4'h4, 32'h0, "rstmid_preset");
        timer_rd(4'h8, 32'h0, "rstmid_count");

`ifdef BRIDGE_TIMEOUT_EN
        ram_access(1'b0, 32'h0000_0100, 4'b0000, 32'h0, -1, 32'h0, 65,
                   32'hDEAD_BEEF, 1'b1, "timeout");
        dm_ack = 1'b1;
        @(negedge clk);
        dm_ack = 1'b0;
        check("timeout_late_ack_ready", resp_ready, 1'b0);
        @(negedge clk);
        check("timeout_late_ack_ready2", resp_ready, 1'b0);
`else
        ram_access(1'b0, 32'h0000_0100, 4'b0000, 32'h0, 100, 32'hCAFE_F00D, 102,
                   32'hCAFE_F00D, 1'b0, "long_wait");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [3:0] OFF_PRESET_TB();
        return 4'h4;
    endfunction

endmodule
